// File: rtl/led_matrix_scanner_if.sv
// Signal bundle between the LED matrix scanner and the game-board/matrix side.
// With BRIGHTNESS_PWM_EN defined, a 4-bit brightness input is added.
interface led_matrix_scanner_if;
    logic       enable;
    logic [0:7] rowR_in;
    logic [0:7] rowG_in;
`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] brightness;
`endif
    logic       count0;
    logic       count1;
    logic       count2;
    logic [0:7] colEn;
    logic [0:7] ledR;
    logic [0:7] ledG;
    logic       frame_done;

`ifdef BRIGHTNESS_PWM_EN
    modport master (
        input  enable, rowR_in, rowG_in, brightness,
        output count0, count1, count2, colEn, ledR, ledG, frame_done
    );
    modport slave (
        output enable, rowR_in, rowG_in, brightness,
        input  count0, count1, count2, colEn, ledR, ledG, frame_done
    );
`else
    modport master (
        input  enable, rowR_in, rowG_in,
        output count0, count1, count2, colEn, ledR, ledG, frame_done
    );
    modport slave (
        output enable, rowR_in, rowG_in,
        input  count0, count1, count2, colEn, ledR, ledG, frame_done
    );
`endif
endinterface

// File: rtl/led_matrix_scanner.sv
// Column-scan driver for an 8x8 red/green LED matrix with blanking and frame pulse.
// Optional row-drive PWM dimming is enabled by defining BRIGHTNESS_PWM_EN.
module led_matrix_scanner #(
    parameter int unsigned BLANK_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned DWELL_CYCLES  = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    led_matrix_scanner_if.master        bus
);

    typedef enum logic [1:0] {StIdle, StBlank, StSettle, StShow} state_e;

    localparam logic [15:0] BlankLoad  = 16'(BLANK_CYCLES - 1);
    localparam logic [15:0] SettleLoad = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] DwellLoad  = 16'(DWELL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  index_q, index_d;
    logic [15:0] timer_q, timer_d;
    logic [0:7]  cap_r_q, cap_r_d;
    logic [0:7]  cap_g_q, cap_g_d;
    logic [0:7]  col_en_q, col_en_d;
    logic [0:7]  led_r_q, led_r_d;
    logic [0:7]  led_g_q, led_g_d;
    logic        frame_done_q, frame_done_d;
    logic        timer_zero;
    logic        rows_on;

`ifdef BRIGHTNESS_PWM_EN
    logic [3:0]  bright_q, bright_d;
`endif

    assign timer_zero = (timer_q == 16'd0);

    // Next-state logic: dropping enable from any active state aborts to IDLE.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        timer_d      = timer_zero ? 16'd0 : timer_q - 16'd1;
        cap_r_d      = cap_r_q;
        cap_g_d      = cap_g_q;
        frame_done_d = 1'b0;
`ifdef BRIGHTNESS_PWM_EN
        bright_d     = bright_q;
`endif
        case (state_q)
            StIdle: begin
                index_d = 3'd0;
                timer_d = 16'd0;
                if (bus.enable) begin
                    state_d = StBlank;
                    timer_d = BlankLoad;
                end
            end
            StBlank: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                    index_d = 3'd0;
                    timer_d = 16'd0;
                end else if (timer_zero) begin
                    state_d = StSettle;
                    timer_d = SettleLoad;
                end
            end
            StSettle: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                    index_d = 3'd0;
                    timer_d = 16'd0;
                end else if (timer_zero) begin
                    state_d = StShow;
                    timer_d = DwellLoad;
                    cap_r_d = bus.rowR_in;
                    cap_g_d = bus.rowG_in;
`ifdef BRIGHTNESS_PWM_EN
                    bright_d = bus.brightness;
`endif
                end
            end
            StShow: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                    index_d = 3'd0;
                    timer_d = 16'd0;
                end else if (timer_zero) begin
                    state_d      = StBlank;
                    index_d      = index_q + 3'd1;
                    timer_d      = BlankLoad;
                    frame_done_d = (index_q == 3'd7);
                end
            end
            default: begin
                state_d = StIdle;
                index_d = 3'd0;
                timer_d = 16'd0;
            end
        endcase
    end

    // Outputs are decoded from next state so the registered drive lines up with the state.
    always_comb begin
`ifdef BRIGHTNESS_PWM_EN
        rows_on = (bright_d == 4'hF) || (timer_d[3:0] < bright_d);
`else
        rows_on = 1'b1;
`endif
        col_en_d = '0;
        led_r_d  = '0;
        led_g_d  = '0;
        if (state_d == StShow) begin
            col_en_d[index_d] = 1'b1;
            if (rows_on) begin
                led_r_d = cap_r_d;
                led_g_d = cap_g_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            index_q      <= 3'd0;
            timer_q      <= 16'd0;
            cap_r_q      <= '0;
            cap_g_q      <= '0;
            col_en_q     <= '0;
            led_r_q      <= '0;
            led_g_q      <= '0;
            frame_done_q <= 1'b0;
`ifdef BRIGHTNESS_PWM_EN
            bright_q     <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            timer_q      <= timer_d;
            cap_r_q      <= cap_r_d;
            cap_g_q      <= cap_g_d;
            col_en_q     <= col_en_d;
            led_r_q      <= led_r_d;
            led_g_q      <= led_g_d;
            frame_done_q <= frame_done_d;
`ifdef BRIGHTNESS_PWM_EN
            bright_q     <= bright_d;
`endif
        end
    end

    assign bus.count0     = index_q[0];
    assign bus.count1     = index_q[1];
    assign bus.count2     = index_q[2];
    assign bus.colEn      = col_en_q;
    assign bus.ledR       = led_r_q;
    assign bus.ledG       = led_g_q;
    assign bus.frame_done = frame_done_q;

endmodule
